// File: rtl/zx_io_master.sv
// zx_io_master: Z80-style I/O bus initiator.
// Turns single-beat requests into full Z80 IN/OUT cycles
// (T1, T2, TW..., T3, REC) on a ZX edge-connector bus.
// Each T-state lasts TCYC clk32 cycles. Every bus-facing output is a flop,
// so strobes and address never glitch.
module zx_io_master #(
  parameter int TCYC     = 9,    // clk32 cycles per T-state, 4..63
  parameter int WAIT_MAX = 255   // max extra TW states before timeout, 1..255
) (
  input  logic        clk32,
  input  logic        rst_n,
  // requester side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_timeout,
  // bus side
  output logic [15:0] a,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic [7:0]  d_in,
  output logic        n_iorq,
  output logic        n_rd,
  output logic        n_wr,
  output logic        n_mreq,
  output logic        n_m1,
  input  logic        n_wait
);

  // Strobes stay low for the first ceil(TCYC/2) cycles of T3.
  localparam int          HALF  = (TCYC + 1) / 2;
  localparam logic [5:0]  TLAST = 6'(TCYC - 1);
  localparam logic [5:0]  SLAST = 6'(HALF - 1);
  localparam logic [7:0]  WMAX  = 8'(WAIT_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_TW, S_T3, S_REC
  } state_t;

  state_t      state;
  logic [5:0]  tcnt;       // position inside the current T-state
  logic [7:0]  wcnt;       // extra TW states inserted so far
  logic        wr_q;       // captured direction
  logic        tmo_q;      // wait limit hit during this cycle
  logic [7:0]  rdata_q;    // read data captured in T3
  logic [1:0]  wait_sync;  // n_wait synchronizer, [1] is the safe copy
  logic        t_last;
  logic        nw_s;

  assign t_last = (tcnt == TLAST);
  assign nw_s   = wait_sync[1];

  // Memory cycles are never issued; the card's I/O decode relies on these.
  assign n_mreq = 1'b1;
  assign n_m1   = 1'b1;

  // Two-flop synchronizer for the asynchronous wait line (idles released).
  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) wait_sync <= 2'b11;
    else        wait_sync <= {wait_sync[0], n_wait};
  end

  // T-state counter: free-runs 0..TCYC-1 whenever a bus cycle is active.
  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n)                         tcnt <= '0;
    else if (state == S_IDLE || t_last) tcnt <= '0;
    else                                tcnt <= tcnt + 6'd1;
  end

  // Bus cycle sequencer with registered strobes, address, data and response.
  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wcnt        <= '0;
      wr_q        <= 1'b0;
      tmo_q       <= 1'b0;
      rdata_q     <= 8'hFF;
      a           <= '0;
      d_out       <= '0;
      d_oe        <= 1'b0;
      n_iorq      <= 1'b1;
      n_rd        <= 1'b1;
      n_wr        <= 1'b1;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 8'hFF;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            state     <= S_T1;
            req_ready <= 1'b0;
            a         <= req_addr;
            wr_q      <= req_wr;
            wcnt      <= '0;
            tmo_q     <= 1'b0;
            if (req_wr) begin
              d_out <= req_wdata;
              d_oe  <= 1'b1;
            end
          end
        end
        S_T1: begin
          if (t_last) begin
            state  <= S_T2;
            n_iorq <= 1'b0;
            n_rd   <= wr_q;
            n_wr   <= ~wr_q;
          end
        end
        S_T2: begin
          // Z80 I/O always gets one automatic wait state.
          if (t_last) state <= S_TW;
        end
        S_TW: begin
          if (t_last) begin
            if (!nw_s && wcnt < WMAX) begin
              wcnt <= wcnt + 8'd1;
            end else begin
              state <= S_T3;
              tmo_q <= ~nw_s;
            end
          end
        end
        S_T3: begin
          if (tcnt == SLAST) begin
            n_iorq  <= 1'b1;
            n_rd    <= 1'b1;
            n_wr    <= 1'b1;
            if (!wr_q) rdata_q <= d_in;
          end
          if (t_last) begin
            state <= S_REC;
            d_oe  <= 1'b0;
          end
        end
        S_REC: begin
          if (t_last) begin
            state       <= S_IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= wr_q ? 8'hFF : rdata_q;
            rsp_timeout <= tmo_q;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zx_io_master.sv
// Directed bench for zx_io_master. A per-cycle checker compares every
// output against a timeline derived from the T-state arithmetic; literal
// latencies and read data pin that model at the end of each transaction.
module tb_zx_io_master;
  localparam int T  = 9;
  localparam int WM = 3;
  localparam int H  = (T + 1) / 2;

  logic        clk32 = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_wr = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid, rsp_timeout;
  logic [7:0]  rsp_rdata;
  logic [15:0] a;
  logic [7:0]  d_out, d_in = 8'h00;
  logic        d_oe, n_iorq, n_rd, n_wr, n_mreq, n_m1;
  logic        n_wait = 1'b1;

  zx_io_master #(.TCYC(T), .WAIT_MAX(WM)) dut (
    .clk32(clk32), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .a(a), .d_out(d_out), .d_oe(d_oe), .d_in(d_in),
    .n_iorq(n_iorq), .n_rd(n_rd), .n_wr(n_wr), .n_mreq(n_mreq), .n_m1(n_m1),
    .n_wait(n_wait)
  );

  always #5 clk32 = ~clk32;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  always @(posedge clk32) edge_n <= edge_n + 1;

  // model of the transaction in flight
  bit          chk_en = 1'b0;
  bit          m_act  = 1'b0;
  int          acc_e, m_L, m_W;
  bit          m_wr, m_tmo;
  logic [15:0] m_last_addr = '0;
  logic [7:0]  m_wdata = '0;
  logic [7:0]  m_rdata = 8'hFF, m_prev_rdata = 8'hFF;
  int          obs_k = -1;
  logic [7:0]  obs_rd;
  logic        obs_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  // per-cycle compare against the model timeline
  int ck;
  bit busy, slow, eoe, ersp;
  always @(negedge clk32) begin
    if (chk_en) begin
      ck   = edge_n - acc_e + 1;
      busy = m_act && ck >= 1 && ck <= m_L;
      slow = busy && ck >= T + 1 && ck <= (3 + m_W) * T + H;
      eoe  = busy && m_wr && ck <= (4 + m_W) * T;
      ersp = m_act && ck == m_L + 1;
      chk("n_iorq", n_iorq, !slow);
      chk("n_rd", n_rd, !(slow && !m_wr));
      chk("n_wr", n_wr, !(slow && m_wr));
      chk("n_mreq_m1", {n_mreq, n_m1}, 2'b11);
      chk("d_oe", d_oe, eoe);
      if (eoe) chk("d_out", d_out, m_wdata);
      chk("a", a, m_last_addr);
      chk("req_ready", req_ready, !busy);
      chk("rsp_valid", rsp_valid, ersp);
      chk("rsp_rdata", rsp_rdata, (m_act && ck > m_L) ? m_rdata : m_prev_rdata);
      if (ersp) chk("rsp_timeout", rsp_timeout, m_tmo);
      if (rsp_valid) begin
        obs_k  = ck;
        obs_rd = rsp_rdata;
        obs_to = rsp_timeout;
      end
    end
  end

  // One bus transaction. n_wait is low for relative cycles nw_s..nw_e,
  // d_in = dval before cycle dchg and 00 from then on. abort_k>0 pulses reset.
  task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [7:0] wd,
                         input int nw_s, input int nw_e,
                         input logic [7:0] dval, input int dchg,
                         input bit keep, input logic [15:0] alt, input int abort_k);
    int  w, l, kc, n;
    bit  tmo;
    w = 0; tmo = 1'b0;
    // synchronized wait seen at the end of TW j is n_wait two cycles earlier
    for (int j = 0; j <= WM; j++) begin
      int c;
      c = (3 + j) * T - 2;
      if (!(c >= nw_s && c <= nw_e)) break;
      if (j == WM) begin tmo = 1'b1; break; end
      w++;
    end
    l  = (5 + w) * T;
    kc = (3 + w) * T + H;
    req_wr = wr; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    @(negedge clk32);
    while (!req_ready && n < 200) begin n++; @(negedge clk32); end
    if (!req_ready) begin
      chk("accept_bound", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk32); #1;
    acc_e = edge_n; m_W = w; m_L = l; m_wr = wr; m_tmo = tmo;
    m_wdata = wd; m_last_addr = addr; m_prev_rdata = m_rdata;
    m_rdata = wr ? 8'hFF : ((kc < dchg) ? dval : 8'h00);
    m_act = 1'b1; obs_k = -1;
    if (!keep) req_valid = 1'b0;
    for (int k = 1; k <= l; k++) begin
      n_wait = !(k >= nw_s && k <= nw_e);
      d_in   = (k < dchg) ? dval : 8'h00;
      if (k == 5 && keep) req_addr = alt;
      if (k == abort_k) begin
        chk("pre_rst_nwr", n_wr, 1'b0);
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("rst_strobes", {n_iorq, n_rd, n_wr}, 3'b111);
        chk("rst_d_oe", d_oe, 1'b0);
        chk("rst_a", a, 16'h0000);
        chk("rst_d_out", d_out, 8'h00);
        chk("rst_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, {2'b00, 8'hFF});
        m_act = 1'b0; m_last_addr = '0; m_rdata = 8'hFF; m_prev_rdata = 8'hFF;
        req_valid = 1'b0; n_wait = 1'b1;
        @(posedge clk32); @(posedge clk32); #1;
        rst_n = 1'b1; chk_en = 1'b1;
        return;
      end
      @(posedge clk32); #1;
    end
    n_wait = 1'b1;
  endtask

  task automatic post(input string name, input int k, input logic [7:0] rd, input logic to);
    @(negedge clk32); #1;
    chk({name, "_rsp_cycle"}, obs_k, k);
    chk({name, "_rdata"}, obs_rd, rd);
    chk({name, "_timeout"}, obs_to, to);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk32);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  int a1;
  initial begin
    idle(3);
    chk("reset_strobes", {n_iorq, n_rd, n_wr, n_mreq, n_m1}, 5'b11111);
    chk("reset_a", a, 16'h0000);
    chk("reset_d_oe", d_oe, 1'b0);
    chk("reset_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, {2'b00, 8'hFF});
    chk("reset_ready", req_ready, 1'b1);
    rst_n = 1'b1; chk_en = 1'b1;
    idle(2);

    // OUT #FFFD, no waits
    run_txn(1'b1, 16'hFFFD, 8'hFE, 1, 0, 8'h00, 0, 1'b0, 16'h0, 0);
    post("out_fffd", 46, 8'hFF, 1'b0);
    idle(3);
    // IN #00BB, d_in drops at cycle 33
    run_txn(1'b0, 16'h00BB, 8'h00, 1, 0, 8'h7E, 33, 1'b0, 16'h0, 0);
    post("in_00bb", 46, 8'h7E, 1'b0);
    idle(2);
    // IN with n_wait low cycles 15..40
    run_txn(1'b0, 16'h00B3, 8'h00, 15, 40, 8'h5A, 1000, 1'b0, 16'h0, 0);
    post("in_wait2", 64, 8'h5A, 1'b0);
    idle(2);
    // OUT with n_wait stuck low: timeout
    run_txn(1'b1, 16'h00FF, 8'h33, 1, 10000, 8'h00, 0, 1'b0, 16'h0, 0);
    post("out_tmo", 73, 8'hFF, 1'b1);
    idle(2);
    // back-to-back, address changes during the first cycle
    run_txn(1'b1, 16'hBFFD, 8'h11, 1, 0, 8'h00, 0, 1'b1, 16'h001F, 0);
    a1 = acc_e;
    run_txn(1'b0, 16'h001F, 8'h00, 1, 0, 8'hC3, 1000, 1'b0, 16'h0, 0);
    chk("b2b_gap", acc_e - a1, 46);
    post("b2b_second", 46, 8'hC3, 1'b0);
    idle(2);
    // reset mid-write at cycle 20
    run_txn(1'b1, 16'hFFFD, 8'hA5, 1, 0, 8'h00, 0, 1'b0, 16'h0, 20);
    obs_k = -1;
    idle(60);
    chk("abort_no_rsp", obs_k, -1);
    // normal cycle after reset
    run_txn(1'b0, 16'hFFFD, 8'h00, 1, 0, 8'h42, 1000, 1'b0, 16'h0, 0);
    post("after_rst", 46, 8'h42, 1'b0);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
